// File: rtl/alu_pkg.sv
// Shared definitions for the UART-to-ALU frame bridge: FSM states and ALU opcodes.
package alu_pkg;

    typedef enum logic [2:0] {
        RX_A_LO = 3'd0,
        RX_A_HI = 3'd1,
        RX_B_LO = 3'd2,
        RX_B_HI = 3'd3,
        RX_OP   = 3'd4,
        EXEC    = 3'd5,
        TX_LO   = 3'd6,
        TX_HI   = 3'd7
    } state_t;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

    function automatic logic is_supported_op(input logic [5:0] op);
        logic hit;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SRA, OP_SRL, OP_NOR: hit = 1'b1;
            default:                        hit = 1'b0;
        endcase
        return hit;
    endfunction

    // States that accept a received byte into a frame field.
    function automatic logic is_rx_state(input state_t s);
        logic hit;
        case (s)
            RX_A_LO, RX_A_HI, RX_B_LO, RX_B_HI, RX_OP: hit = 1'b1;
            default:                                   hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Mid-frame states where the inter-byte timer runs.
    function automatic logic is_count_state(input state_t s);
        logic hit;
        case (s)
            RX_A_HI, RX_B_LO, RX_B_HI, RX_OP: hit = 1'b1;
            default:                          hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic logic is_busy_state(input state_t s);
        logic hit;
        case (s)
            EXEC, TX_LO, TX_HI: hit = 1'b1;
            default:            hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/alu_uart_timeout.sv
// Inter-byte idle timer: counts enabled cycles and pulses expire on the
// TIMEOUT-th consecutive one, restarting from zero afterwards.
module alu_uart_timeout #(
    parameter int TIMEOUT = 50_000_000,
    parameter int TO_W    = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [TO_W-1:0] count_r;
    logic            expire_s;

    // Expiry fires while the count sits one below the limit and another idle cycle arrives.
    always_comb begin
        expire_s = 1'b0;
        if (enable && (count_r == TO_W'(TIMEOUT - 1))) begin
            expire_s = 1'b1;
        end else begin
            expire_s = 1'b0;
        end
    end

    // Idle-cycle counter with clear priority over counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {TO_W{1'b0}};
        end else if (clear || expire_s) begin
            count_r <= {TO_W{1'b0}};
        end else if (enable) begin
            count_r <= count_r + {{(TO_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign expire = expire_s;

endmodule

// File: rtl/alu_uart_if.sv
// Frame bridge: collects A, B and opcode from five UART bytes, drives the ALU,
// then returns the registered 16-bit result as two transmitted bytes.
module alu_uart_if
    import alu_pkg::*;
#(
    parameter int BUS_REG = 16,
    parameter int BUS_OP  = 6,
    parameter int TIMEOUT = 50_000_000,
    parameter int TO_W    = 26
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    input  logic [BUS_REG-1:0] i_result,
    output logic [BUS_REG-1:0] o_valA,
    output logic [BUS_REG-1:0] o_valB,
    output logic [BUS_OP-1:0]  o_opcode,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_frame_err
);

    state_t             state_r;
    state_t             state_s;
    logic [BUS_REG-1:0] val_a_r;
    logic [BUS_REG-1:0] val_b_r;
    logic [BUS_OP-1:0]  opcode_r;
    logic [BUS_REG-1:0] result_r;
    logic [7:0]         tx_data_r;
    logic [7:0]         tx_data_s;
    logic               tx_start_r;
    logic               tx_start_s;
    logic               busy_r;
    logic               frame_err_r;
    logic               accept_s;
    logic               expire_s;
    logic               to_enable_s;
    logic               to_clear_s;

    // Bytes arriving while busy fall outside is_rx_state and are dropped.
    always_comb begin
        accept_s    = i_rx_done && is_rx_state(state_r);
        to_enable_s = is_count_state(state_r) && !i_rx_done;
        to_clear_s  = accept_s || !is_count_state(state_r);
    end

    alu_uart_timeout #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .clk    (i_clk),
        .reset  (i_reset),
        .clear  (to_clear_s),
        .enable (to_enable_s),
        .expire (expire_s)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r <= RX_A_LO;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic plus the next values of the transmit handshake.
    always_comb begin
        state_s    = state_r;
        tx_start_s = 1'b0;
        tx_data_s  = tx_data_r;
        case (state_r)
            RX_A_LO: begin
                if (i_rx_done) state_s = RX_A_HI;
                else           state_s = RX_A_LO;
            end
            RX_A_HI: begin
                if (i_rx_done)     state_s = RX_B_LO;
                else if (expire_s) state_s = RX_A_LO;
                else               state_s = RX_A_HI;
            end
            RX_B_LO: begin
                if (i_rx_done)     state_s = RX_B_HI;
                else if (expire_s) state_s = RX_A_LO;
                else               state_s = RX_B_LO;
            end
            RX_B_HI: begin
                if (i_rx_done)     state_s = RX_OP;
                else if (expire_s) state_s = RX_A_LO;
                else               state_s = RX_B_HI;
            end
            RX_OP: begin
                if (i_rx_done)     state_s = EXEC;
                else if (expire_s) state_s = RX_A_LO;
                else               state_s = RX_OP;
            end
            EXEC: begin
                // The low byte comes straight from the ALU so the start pulse lands on TX_LO entry.
                state_s    = TX_LO;
                tx_start_s = 1'b1;
                tx_data_s  = i_result[7:0];
            end
            TX_LO: begin
                if (i_tx_done) begin
                    state_s    = TX_HI;
                    tx_start_s = 1'b1;
                    tx_data_s  = result_r[BUS_REG-1:8];
                end else begin
                    state_s    = TX_LO;
                end
            end
            TX_HI: begin
                if (i_tx_done) state_s = RX_A_LO;
                else           state_s = TX_HI;
            end
            default: begin
                state_s = RX_A_LO;
            end
        endcase
    end

    // Frame field registers, written bytewise as each byte is accepted.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            val_a_r  <= {BUS_REG{1'b0}};
            val_b_r  <= {BUS_REG{1'b0}};
            opcode_r <= {BUS_OP{1'b0}};
        end else if (accept_s) begin
            case (state_r)
                RX_A_LO: val_a_r[7:0]         <= i_rx_data;
                RX_A_HI: val_a_r[BUS_REG-1:8] <= i_rx_data;
                RX_B_LO: val_b_r[7:0]         <= i_rx_data;
                RX_B_HI: val_b_r[BUS_REG-1:8] <= i_rx_data;
                RX_OP:   opcode_r             <= i_rx_data[BUS_OP-1:0];
                default: opcode_r             <= opcode_r;
            endcase
        end else begin
            val_a_r  <= val_a_r;
            val_b_r  <= val_b_r;
            opcode_r <= opcode_r;
        end
    end

    // Result capture during EXEC and the registered status/transmit outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            result_r    <= {BUS_REG{1'b0}};
            tx_data_r   <= 8'h00;
            tx_start_r  <= 1'b0;
            busy_r      <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            if (state_r == EXEC) result_r <= i_result;
            else                 result_r <= result_r;
            tx_data_r   <= tx_data_s;
            tx_start_r  <= tx_start_s;
            busy_r      <= is_busy_state(state_s);
            frame_err_r <= expire_s;
        end
    end

    assign o_valA      = val_a_r;
    assign o_valB      = val_b_r;
    assign o_opcode    = opcode_r;
    assign o_tx_data   = tx_data_r;
    assign o_tx_start  = tx_start_r;
    assign o_busy      = busy_r;
    assign o_frame_err = frame_err_r;

endmodule

// File: tb/tb_alu_uart_if.sv
// Self-checking bench for alu_uart_if: directed frames from the test plan plus
// randomized frames, with a behavioural ALU and frame model inside the bench.
module tb_alu_uart_if;

    localparam int TO = 100;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [7:0]  i_rx_data;
    logic        i_rx_done;
    logic        i_tx_done;
    logic [15:0] i_result;
    logic [15:0] o_valA;
    logic [15:0] o_valB;
    logic [5:0]  o_opcode;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        o_busy;
    logic        o_frame_err;

    int n_cmp = 0;
    int n_bad = 0;
    bit start_pending = 1'b0;

    alu_uart_if #(.TIMEOUT(TO), .TO_W(26)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_rx_data   (i_rx_data),
        .i_rx_done   (i_rx_done),
        .i_tx_done   (i_tx_done),
        .i_result    (i_result),
        .o_valA      (o_valA),
        .o_valB      (o_valB),
        .o_opcode    (o_opcode),
        .o_tx_data   (o_tx_data),
        .o_tx_start  (o_tx_start),
        .o_busy      (o_busy),
        .o_frame_err (o_frame_err)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [15:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                            input logic [5:0] op);
        logic [15:0] r;
        case (op)
            6'h20:   r = a + b;
            6'h22:   r = a - b;
            6'h24:   r = a & b;
            6'h25:   r = a | b;
            6'h26:   r = a ^ b;
            6'h27:   r = ~(a | b);
            6'h03:   r = 16'($signed(a) >>> b);
            6'h02:   r = a >> b;
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    assign i_result = alu_ref(o_valA, o_valB, o_opcode);

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // A start pulse must not recur until the transmitter has reported done.
    always @(posedge i_clk) begin
        #1;
        if (i_reset || i_tx_done) start_pending = 1'b0;
        if (o_tx_start) begin
            check_eq("start_before_done", 64'(start_pending), 64'd0);
            start_pending = 1'b1;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            if ($urandom_range(0, 3) == 0) i_tx_done = 1'b1;
            @(negedge i_clk);
            i_tx_done = 1'b0;
        end
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(negedge i_clk);
        i_rx_done = 1'b0;
        i_rx_data = 8'($urandom);
    endtask

    function automatic logic [63:0] all_outs();
        return {15'd0, o_valA, o_valB, o_opcode, o_tx_data, o_tx_start, o_busy, o_frame_err};
    endfunction

    task automatic run_frame(input logic [39:0] fr, input int dly, input bit inj_exec,
                             input bit inj_txlo, input bit rst_txhi, input string tag);
        logic [15:0] a, b, r;
        logic [5:0]  op;
        int          bad;
        a  = fr[15:0];
        b  = fr[31:16];
        op = fr[37:32];
        r  = alu_ref(a, b, op);
        if (dly < 1) dly = 1;
        for (int i = 0; i < 5; i++) send_byte(fr[8*i +: 8], $urandom_range(0, 3));
        check_eq({tag, ".start_early"}, 64'(o_tx_start), 64'd0);
        check_eq({tag, ".busy_exec"}, 64'(o_busy), 64'd1);
        if (inj_exec) begin i_rx_data = 8'hAA; i_rx_done = 1'b1; end
        @(negedge i_clk);
        i_rx_done = 1'b0;
        check_eq({tag, ".start_lo"}, 64'(o_tx_start), 64'd1);
        check_eq({tag, ".data_lo"}, 64'(o_tx_data), 64'(r[7:0]));
        if (inj_txlo) begin i_rx_data = 8'hAA; i_rx_done = 1'b1; end
        bad = 0;
        repeat (dly) begin
            @(negedge i_clk);
            i_rx_done = 1'b0;
            if (o_tx_start !== 1'b0 || o_busy !== 1'b1 || o_tx_data !== r[7:0]) bad++;
        end
        check_eq({tag, ".hold_lo"}, 64'(bad), 64'd0);
        i_tx_done = 1'b1;
        @(negedge i_clk);
        i_tx_done = 1'b0;
        check_eq({tag, ".start_hi"}, 64'(o_tx_start), 64'd1);
        check_eq({tag, ".data_hi"}, 64'(o_tx_data), 64'(r[15:8]));
        bad = 0;
        repeat (dly) begin
            @(negedge i_clk);
            if (o_tx_start !== 1'b0 || o_busy !== 1'b1 || o_tx_data !== r[15:8]) bad++;
        end
        check_eq({tag, ".hold_hi"}, 64'(bad), 64'd0);
        if (rst_txhi) begin
            i_reset = 1'b1;
            @(negedge i_clk);
            i_reset = 1'b0;
            check_eq({tag, ".rst_outs"}, all_outs(), 64'd0);
            bad = 0;
            repeat (10) begin
                @(negedge i_clk);
                if (o_tx_start !== 1'b0) bad++;
            end
            check_eq({tag, ".rst_quiet"}, 64'(bad), 64'd0);
        end else begin
            i_tx_done = 1'b1;
            @(negedge i_clk);
            i_tx_done = 1'b0;
            check_eq({tag, ".busy_end"}, 64'(o_busy), 64'd0);
            check_eq({tag, ".valA"}, 64'(o_valA), 64'(a));
            check_eq({tag, ".valB"}, 64'(o_valB), 64'(b));
            check_eq({tag, ".opcode"}, 64'(o_opcode), 64'(op));
        end
    endtask

    initial begin
        logic [7:0]  ops [8];
        logic [39:0] fr;
        logic [7:0]  opb;
        int          pulses, first;
        ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h03, 8'h02, 8'h27};

        i_reset = 1'b1; i_rx_data = 8'h00; i_rx_done = 1'b0; i_tx_done = 1'b0;
        repeat (3) @(negedge i_clk);
        check_eq("reset_outs", all_outs(), 64'd0);
        i_reset = 1'b0;
        @(negedge i_clk);
        check_eq("idle_outs", all_outs(), 64'd0);

        run_frame({8'h20, 8'h00, 8'h11, 8'h12, 8'h34}, 2, 1'b0, 1'b0, 1'b0, "add");
        check_eq("add.result", 64'(alu_ref(o_valA, o_valB, o_opcode)), 64'h1245);
        run_frame({8'h03, 8'h00, 8'h04, 8'h80, 8'h00}, 3, 1'b0, 1'b0, 1'b0, "sra");
        run_frame({8'hE2, 8'h00, 8'h05, 8'h00, 8'h10}, 1, 1'b0, 1'b0, 1'b0, "sub_e2");
        check_eq("sub_e2.op", 64'(o_opcode), 64'h22);

        send_byte(8'h78, 1);
        send_byte(8'h56, 0);
        pulses = 0;
        first  = -1;
        for (int k = 1; k <= TO + 10; k++) begin
            @(negedge i_clk);
            if (o_frame_err) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        check_eq("to.pulses", 64'(pulses), 64'd1);
        check_eq("to.when", 64'(first >= TO - 1 && first <= TO + 1), 64'd1);
        check_eq("to.partialA", 64'(o_valA), 64'h5678);
        check_eq("to.busy", 64'(o_busy), 64'd0);
        run_frame({8'h25, 8'h00, 8'h02, 8'h00, 8'h01}, 2, 1'b0, 1'b0, 1'b0, "or_after_to");

        run_frame({8'h20, 8'h01, 8'h02, 8'h03, 8'h04}, 3, 1'b1, 1'b0, 1'b0, "drop_exec");
        run_frame({8'h26, 8'h5A, 8'h5A, 8'h0F, 8'hF0}, 3, 1'b0, 1'b1, 1'b0, "drop_txlo");
        run_frame({8'h22, 8'h00, 8'h01, 8'h00, 8'h00}, 2, 1'b0, 1'b0, 1'b0, "after_drop");

        send_byte(8'h11, 1);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        check_eq("rst_mid.outs", all_outs(), 64'd0);
        run_frame({8'h24, 8'h0F, 8'hF0, 8'hFF, 8'h0F}, 2, 1'b0, 1'b0, 1'b0, "after_rst_mid");
        run_frame({8'h27, 8'h12, 8'h34, 8'h56, 8'h78}, 2, 1'b0, 1'b0, 1'b1, "rst_txhi");
        run_frame({8'h02, 8'h00, 8'h03, 8'hF0, 8'h00}, 2, 1'b0, 1'b0, 1'b0, "after_rst_tx");
        run_frame({8'h20, 8'hFF, 8'hFF, 8'h00, 8'h01}, 20, 1'b0, 1'b0, 1'b0, "holdoff");
        run_frame({8'h3F, 8'h12, 8'h34, 8'h56, 8'h78}, 2, 1'b0, 1'b0, 1'b0, "unsupported");
        check_eq("unsupported.res", 64'(alu_ref(o_valA, o_valB, o_opcode)), 64'd0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) opb = 8'($urandom);
            else opb = ops[$urandom_range(0, 7)] | {2'($urandom), 6'd0};
            fr = {opb, 16'($urandom), 16'($urandom)};
            run_frame(fr, $urandom_range(1, 6), 1'($urandom), 1'($urandom), 1'b0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
